output_layer_mac: RTL

- Fixed-point multiply-accumulate stage that computes the output-layer neurons and streams them, one result per neuron, into the softmax normalizer directly downstream.
- Each neuron is computed as: sum over N_IN beats of act*wgt, plus bias, then rounded, passed through ReLU and saturated. ReLU guarantees the normalizer only ever sums non-negative outputs.
- Neurons are emitted in index order 0..N_OUT-1; m_last marks the final neuron of the layer.

---
 rtl/output_layer_mac_if.sv | 36 +++
 rtl/output_layer_mac.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/output_layer_mac_if.sv
// Streaming interface between the output-layer MAC and its neighbours.
//   s_valid/s_ready : input beat handshake (activation, weight, bias)
//   s_act/s_wgt     : signed Q-format activation and weight
//   s_bias          : signed bias, used only on the first beat of a neuron
//   m_valid/m_ready : result handshake towards the softmax normalizer
//   m_data          : non-negative neuron result, same Q format
//   m_index         : neuron index of m_data
//   m_last          : marks the final neuron of the layer
// master = producer of beats / consumer of results, slave = the MAC.
interface output_layer_mac_if #(
    parameter int DATA_W = 16,
    parameter int N_OUT  = 10
);
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_act;
    logic signed [DATA_W-1:0] s_wgt;
    logic signed [DATA_W-1:0] s_bias;
    logic                     m_valid;
    logic                     m_ready;
    logic        [DATA_W-1:0] m_data;
    logic        [IDX_W-1:0]  m_index;
    logic                     m_last;

    modport master (
        output s_valid, s_act, s_wgt, s_bias, m_ready,
        input  s_ready, m_valid, m_data, m_index, m_last
    );

    modport slave (
        input  s_valid, s_act, s_wgt, s_bias, m_ready,
        output s_ready, m_valid, m_data, m_index, m_last
    );
endinterface

// File: rtl/output_layer_mac.sv
// Output-layer multiply-accumulate: for each neuron, accumulates N_IN
// act*wgt products, adds the bias, rounds half-up back to DATA_W, applies
// ReLU and saturation, then presents one result per neuron in index order.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : output_layer_mac_if slave (input beats in, neuron results out)
module output_layer_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 12,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 10,
    parameter int ACC_W  = 40
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output_layer_mac_if.slave  bus
);
    localparam int K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    if (ACC_W < 2*DATA_W + $clog2(N_IN) + 1) begin : g_bad_acc_w
        $error("output_layer_mac: ACC_W too narrow for DATA_W/N_IN");
    end
    if (N_IN < 2 || N_OUT < 2) begin : g_bad_dims
        $error("output_layer_mac: N_IN and N_OUT must be >= 2");
    end

    typedef enum logic [1:0] {ACC, FINAL, OUT} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [K_W-1:0]           r_k;
    logic [IDX_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_bias;
    logic                     r_m_valid;
    logic [DATA_W-1:0]        r_m_data;
    logic [IDX_W-1:0]         r_m_index;
    logic                     r_m_last;

    logic                       w_s_ready;
    logic                       w_hs;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_sh;
    logic signed [ACC_W-1:0]    w_t;
    logic signed [ACC_W-1:0]    w_r;
    logic [DATA_W-1:0]          w_result;

    // Datapath: full-precision product, bias aligned to 2*FRAC fraction bits.
    assign w_prod     = bus.s_act * bus.s_wgt;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_sh  = {{(ACC_W-DATA_W-FRAC){r_bias[DATA_W-1]}}, r_bias, {FRAC{1'b0}}};
    assign w_t        = r_acc + w_bias_sh;
    assign w_r        = (w_t + HALF) >>> FRAC;

    always_comb begin
        w_result = w_r[DATA_W-1:0];
        if (w_r[ACC_W-1]) begin
            w_result = '0;
        end else if (w_r > MAXV) begin
            w_result = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign w_hs = bus.s_valid && (r_state == ACC);

    always_comb begin
        w_next    = r_state;
        w_s_ready = 1'b0;
        case (r_state)
            ACC: begin
                w_s_ready = 1'b1;
                if (w_hs && r_k == K_LAST) begin
                    w_next = FINAL;
                end
            end
            FINAL: w_next = OUT;
            OUT: begin
                if (r_m_valid && bus.m_ready) begin
                    w_next = ACC;
                end
            end
            default: w_next = ACC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ACC;
            r_k       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_bias    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_index <= '0;
            r_m_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ACC: begin
                    if (w_hs) begin
                        // First beat overwrites so no clear cycle is needed.
                        if (r_k == '0) begin
                            r_acc  <= w_prod_ext;
                            r_bias <= bus.s_bias;
                        end else begin
                            r_acc <= r_acc + w_prod_ext;
                        end
                        r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                    end
                end
                FINAL: begin
                    r_m_data  <= w_result;
                    r_m_index <= r_cnt;
                    r_m_last  <= (r_cnt == CNT_LAST);
                    r_m_valid <= 1'b1;
                end
                OUT: begin
                    if (r_m_valid && bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_index = r_m_index;
    assign bus.m_last  = r_m_last;
endmodule
